apb_slave_mem: RTL and testbench

- Parametrised APB slave: word-addressed register memory with byte-strobe writes, programmable wait states and busy stretch.
- Flags out-of-range and read-only accesses with pslverr.
- Sits behind the APB bridge as the next-generation storage slave. Replaces the fixed-width, zero-wait slave.

---
 rtl/apb_slave_mem_pkg.sv | 23 ++
 rtl/apb_slave_mem_if.sv | 31 +++
 rtl/apb_slave_mem_bytemem.sv | 46 ++++
 rtl/apb_slave_mem.sv | 122 ++++++++++++
 tb/tb_apb_slave_mem.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_mem_pkg.sv
// Shared types and helpers for the APB storage slave.
//   state_e    : transfer FSM states
//   CNT_W      : wait-state counter width (WAIT_STATES range 0..15)
//   strb_width : byte-lane count for a given data width
//   idx_width  : word-index width for a given memory depth (minimum 1)
package apb_slave_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int CNT_W = 4;

    function automatic int strb_width(input int data_size);
        return data_size / 8;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a master (bridge) and the storage slave.
//   psel, penable, pwrite, paddr, pwdata, pstrb : request from master
//   pbusy                                       : slave-side stall input
//   pready, prdata, pslverr                     : response from slave
interface apb_slave_mem_if
    import apb_slave_mem_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
);
    logic                             psel;
    logic                             penable;
    logic                             pwrite;
    logic [ADDR_SIZE-1:0]             paddr;
    logic [DATA_SIZE-1:0]             pwdata;
    logic [strb_width(DATA_SIZE)-1:0] pstrb;
    logic                             pbusy;
    logic                             pready;
    logic [DATA_SIZE-1:0]             prdata;
    logic                             pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pbusy,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pbusy,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_bytemem.sv
// Word array with per-byte write enables and an asynchronous read port.
//   clk, rst            : clock, async active-high reset (reloads contents)
//   we, waddr, wstrb,   : write port; lanes with wstrb[b]=1 take wdata lane b
//   wdata
//   raddr, rdata        : combinational read port
// Word 0 resets to ID_VALUE, all other words to zero.
module apb_slave_mem_bytemem
    import apb_slave_mem_pkg::*;
#(
    parameter int          DATA_SIZE = 32,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] ID_VALUE  = 32'hA5B0_0001,
    localparam int         STRB_W    = strb_width(DATA_SIZE),
    localparam int         IDX_W     = idx_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [STRB_W-1:0]    wstrb,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [IDX_W-1:0]     raddr,
    output logic [DATA_SIZE-1:0] rdata
);
    localparam logic [DATA_SIZE-1:0] ID_WORD = DATA_SIZE'(ID_VALUE);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == 0) ? ID_WORD : '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Out-of-range indices are never consumed: the caller masks them via its error decode.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB storage slave: word-addressed memory with byte-strobe writes,
// programmable wait states and a pbusy stall.
//   pclk    : clock, all state on rising edge
//   preset  : asynchronous active-high reset
//   bus     : APB slave modport (psel/penable/pwrite/paddr/pwdata/pstrb/pbusy in,
//             pready/prdata/pslverr out)
// Out-of-range addresses and writes to the read-only ID word (word 0) complete
// with pslverr and leave memory untouched.
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int          DATA_SIZE   = 32,
    parameter int          ADDR_SIZE   = 10,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic         pclk,
    input  logic         preset,
    apb_slave_mem_if.slave bus
);
    localparam int STRB_W = strb_width(DATA_SIZE);
    localparam int IDX_W  = idx_width(DEPTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 write_q, write_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [STRB_W-1:0]    strb_q, strb_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;

    logic                 addr_err;
    logic                 ready;
    logic                 mem_we;
    logic [DATA_SIZE-1:0] mem_rdata;

    assign addr_err = (32'(bus.paddr) >= 32'(DEPTH)) || (bus.pwrite && (bus.paddr == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        write_d = write_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // penable=1 without a preceding setup phase is ignored here.
                if (bus.psel && !bus.penable) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    err_d   = addr_err;
                    write_d = bus.pwrite;
                    idx_d   = bus.paddr[IDX_W-1:0];
                    strb_d  = bus.pstrb;
                    wdata_d = bus.pwdata;
                    rdata_d = (!bus.pwrite && !addr_err) ? mem_rdata : '0;
                end
            end
            ACCESS: begin
                // The counter keeps running under pbusy so a long stall does not add wait states.
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                ready = bus.psel && bus.penable && (cnt_q == '0) && !bus.pbusy;
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = IDLE;
                    mem_we  = write_q && !err_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.pready  = ready;
    assign bus.prdata  = (ready && !write_q) ? rdata_q : '0;
    assign bus.pslverr = ready && err_q;

    apb_slave_mem_bytemem #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .ID_VALUE  (ID_VALUE)
    ) u_mem (
        .clk   (pclk),
        .rst   (preset),
        .we    (mem_we),
        .waddr (idx_q),
        .wstrb (strb_q),
        .wdata (wdata_q),
        .raddr (bus.paddr[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (WAIT_STATES=2 and 0) share clock,
// reset and request wires; dsel routes psel to one of them and picks its response.
module tb_apb_slave_mem;

    logic        pclk;
    logic        preset;
    logic        dsel;
    logic        psel, penable, pwrite, pbusy;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        rdy, serr;
    logic [31:0] rdat;

    int total = 0;
    int bad   = 0;

    apb_slave_mem_if #(.DATA_SIZE(32), .ADDR_SIZE(10)) bus_a ();
    apb_slave_mem_if #(.DATA_SIZE(32), .ADDR_SIZE(10)) bus_b ();

    assign bus_a.psel    = psel & ~dsel;
    assign bus_a.penable = penable;
    assign bus_a.pwrite  = pwrite;
    assign bus_a.paddr   = paddr;
    assign bus_a.pwdata  = pwdata;
    assign bus_a.pstrb   = pstrb;
    assign bus_a.pbusy   = pbusy;

    assign bus_b.psel    = psel & dsel;
    assign bus_b.penable = penable;
    assign bus_b.pwrite  = pwrite;
    assign bus_b.paddr   = paddr;
    assign bus_b.pwdata  = pwdata;
    assign bus_b.pstrb   = pstrb;
    assign bus_b.pbusy   = pbusy;

    assign rdy  = dsel ? bus_b.pready  : bus_a.pready;
    assign rdat = dsel ? bus_b.prdata  : bus_a.prdata;
    assign serr = dsel ? bus_b.pslverr : bus_a.pslverr;

    apb_slave_mem #(
        .DATA_SIZE(32), .ADDR_SIZE(10), .DEPTH(16), .WAIT_STATES(2), .ID_VALUE(32'hA5B0_0001)
    ) dut_a (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_a)
    );

    apb_slave_mem #(
        .DATA_SIZE(32), .ADDR_SIZE(10), .DEPTH(16), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)
    ) dut_b (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge with the bus idle,
    // so a following call issues its setup in the very next cycle. Request fields are
    // scrambled during ACCESS: the slave must use the values latched at setup.
    task automatic xfer(input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output int acc);
        bit done;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = ~addr;
        pwdata  = ~wd;
        pstrb   = ~st;
        rd   = '0;
        er   = 1'b0;
        acc  = 0;
        done = 1'b0;
        while (!done && acc < 40) begin
            acc++;
            @(negedge pclk);
            if (rdy) begin
                rd   = rdat;
                er   = serr;
                done = 1'b1;
            end
            @(posedge pclk); #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: no pready for addr %h after %0d cycles", addr, acc);
            acc = -1;
        end
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
    endtask

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic [31:0] rd;
    logic        er;
    int          acc;

    initial begin
        vecs[0]  = '{1'b0, 10'd0,  32'h0000_0000, 4'h0, 32'hA5B0_0001, 1'b0};
        vecs[1]  = '{1'b0, 10'd5,  32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 10'd3,  32'h1122_3344, 4'b0101, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 10'd3,  32'h0000_0000, 4'h0, 32'h0022_0044, 1'b0};
        vecs[4]  = '{1'b1, 10'd0,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 10'd0,  32'h0000_0000, 4'h0, 32'hA5B0_0001, 1'b0};
        vecs[6]  = '{1'b0, 10'd20, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, 10'd15, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 10'd15, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 10'd15, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 10'd15, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b1, 10'd16, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 10'd3,  32'hAABB_CCDD, 4'b1010, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 10'd3,  32'h0000_0000, 4'h0, 32'hAA22_CC44, 1'b0};

        dsel    = 1'b0;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        pbusy   = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        preset  = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("reset pready",  32'(rdy),  32'h0);
        check("reset prdata",  rdat,      32'h0);
        check("reset pslverr", 32'(serr), 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        preset  = 1'b0;
        @(posedge pclk); #1;

        // Table: WAIT_STATES=2, each transfer needs 3 access cycles.
        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st, rd, er, acc);
            check($sformatf("vec%0d prdata", i),  rd,      vecs[i].exp_rd);
            check($sformatf("vec%0d pslverr", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d cycles", i),  32'(acc), 32'd3);
        end

        // Zero-wait instance: back-to-back writes then reads, one access cycle each.
        dsel = 1'b1;
        for (int a = 1; a <= 5; a++) begin
            xfer(1'b1, 10'(a), 32'(a) * 32'h0101_0101, 4'hF, rd, er, acc);
            check($sformatf("b2b wr%0d pslverr", a), 32'(er),  32'h0);
            check($sformatf("b2b wr%0d cycles", a),  32'(acc), 32'd1);
        end
        for (int a = 1; a <= 5; a++) begin
            xfer(1'b0, 10'(a), 32'h0, 4'h0, rd, er, acc);
            check($sformatf("b2b rd%0d prdata", a), rd,       32'(a) * 32'h0101_0101);
            check($sformatf("b2b rd%0d cycles", a), 32'(acc), 32'd1);
        end
        dsel = 1'b0;

        // pbusy held for 4 access cycles on a read of word 3.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 10'd3;
        @(posedge pclk); #1;
        penable = 1'b1;
        pbusy   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check($sformatf("busy%0d pready", i), 32'(rdy), 32'h0);
            check($sformatf("busy%0d prdata", i), rdat,     32'h0);
            @(posedge pclk); #1;
        end
        pbusy = 1'b0;
        @(negedge pclk);
        check("busy release pready", 32'(rdy), 32'h1);
        check("busy release prdata", rdat,     32'hAA22_CC44);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;

        // Access phase without a setup phase must be ignored.
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 10'd4;
        pwdata  = 32'h1234_5678;
        pstrb   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check($sformatf("nosetup%0d pready", i), 32'(rdy), 32'h0);
            @(posedge pclk); #1;
        end
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        xfer(1'b0, 10'd4, 32'h0, 4'h0, rd, er, acc);
        check("nosetup word4", rd, 32'h0);

        // psel dropped mid-ACCESS on a write: abort, memory untouched.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'd7;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort access pready", 32'(rdy), 32'h0);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        check("abort idle pready", 32'(rdy), 32'h0);
        @(posedge pclk); #1;
        xfer(1'b0, 10'd7, 32'h0, 4'h0, rd, er, acc);
        check("abort word7",        rd,       32'h0);
        check("abort after cycles", 32'(acc), 32'd3);

        // Reset asserted while a write is presenting pready.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'd9;
        pwdata  = 32'h1234_5678;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            @(posedge pclk); #1;
        end
        @(negedge pclk);
        check("pre-reset pready", 32'(rdy), 32'h1);
        #1;
        preset = 1'b1;
        #1;
        check("midreset pready",  32'(rdy),  32'h0);
        check("midreset pslverr", 32'(serr), 32'h0);
        check("midreset prdata",  rdat,      32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk); #1;
        xfer(1'b0, 10'd9, 32'h0, 4'h0, rd, er, acc);
        check("post-reset word9", rd, 32'h0);
        xfer(1'b0, 10'd3, 32'h0, 4'h0, rd, er, acc);
        check("post-reset word3", rd, 32'h0);
        xfer(1'b0, 10'd15, 32'h0, 4'h0, rd, er, acc);
        check("post-reset word15", rd, 32'h0);
        xfer(1'b0, 10'd0, 32'h0, 4'h0, rd, er, acc);
        check("post-reset word0", rd, 32'hA5B0_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
